// File: rtl/sa2_input_loader_pkg.sv
// Shared definitions for the 2x systolic-array input loader: data width,
// FSM state encoding and per-frame element counts.
package sa2_input_loader_pkg;

    localparam int DATA_W = 8;
    localparam int N_W    = 9;
    localparam int N_A    = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        LOAD_W,
        LOAD_A,
        FIRE,
        WAIT
    } state_t;

endpackage

// File: rtl/sa2_input_loader.sv
// Streams a 3x3 kernel and a 4x4 input tile into flat registers, then pulses the
// systolic array and holds the operands until it reports completion.
module sa2_input_loader #(
    parameter int DATA_W = sa2_input_loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              keep_w,
    input  logic              done_sa2,
    output logic              active_sa2,
    output logic              busy,
    output logic [DATA_W-1:0] a11, a12, a13, a14,
    output logic [DATA_W-1:0] a21, a22, a23, a24,
    output logic [DATA_W-1:0] a31, a32, a33, a34,
    output logic [DATA_W-1:0] a41, a42, a43, a44,
    output logic [DATA_W-1:0] b11, b12, b13,
    output logic [DATA_W-1:0] b21, b22, b23,
    output logic [DATA_W-1:0] b31, b32, b33
);
    import sa2_input_loader_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_reg [N_A];
    logic [DATA_W-1:0]  b_reg [N_W];

    // The element counter is shared by both loads and restarts at zero on every state exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_W;
            cnt   <= '0;
            for (int i = 0; i < N_A; i++) a_reg[i] <= '0;
            for (int i = 0; i < N_W; i++) b_reg[i] <= '0;
        end else begin
            case (state)
                LOAD_W: begin
                    if (in_valid) begin
                        b_reg[cnt[3:0]] <= in_data;
                        if (cnt == CNT_W'(N_W - 1)) begin
                            cnt   <= '0;
                            state <= LOAD_A;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        a_reg[cnt[3:0]] <= in_data;
                        if (cnt == CNT_W'(N_A - 1)) begin
                            cnt   <= '0;
                            state <= FIRE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_sa2) begin
                        cnt   <= '0;
                        state <= keep_w ? LOAD_A : LOAD_W;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= LOAD_W;
                end
            endcase
        end
    end

    assign in_ready   = (state == LOAD_W) || (state == LOAD_A);
    assign active_sa2 = (state == FIRE);
    assign busy       = (state == FIRE) || (state == WAIT);

    assign a11 = a_reg[0];
    assign a12 = a_reg[1];
    assign a13 = a_reg[2];
    assign a14 = a_reg[3];
    assign a21 = a_reg[4];
    assign a22 = a_reg[5];
    assign a23 = a_reg[6];
    assign a24 = a_reg[7];
    assign a31 = a_reg[8];
    assign a32 = a_reg[9];
    assign a33 = a_reg[10];
    assign a34 = a_reg[11];
    assign a41 = a_reg[12];
    assign a42 = a_reg[13];
    assign a43 = a_reg[14];
    assign a44 = a_reg[15];

    assign b11 = b_reg[0];
    assign b12 = b_reg[1];
    assign b13 = b_reg[2];
    assign b21 = b_reg[3];
    assign b22 = b_reg[4];
    assign b23 = b_reg[5];
    assign b31 = b_reg[6];
    assign b32 = b_reg[7];
    assign b33 = b_reg[8];

endmodule

// File: tb/tb_sa2_input_loader.sv
// Self-checking bench for sa2_input_loader: table-driven frame loads, directed
// corner cases and randomized traffic against a frame-level reference model.
module tb_sa2_input_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       keep_w = 1'b0;
    logic       done_sa2 = 1'b0;
    logic       in_ready, active_sa2, busy;
    logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
    logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes received this frame, whether the kernel is needed,
    // and a phase of 0 = loading, 1 = start cycle, 2 = awaiting done.
    logic [7:0] m_a [16];
    logic [7:0] m_b [9];
    bit         m_need_w;
    int         m_taken;
    int         m_phase;

    int cyc;
    int fire_cycle;
    int fire_count;

    logic [7:0] dut_a [16];
    logic [7:0] dut_b [9];

    sa2_input_loader #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .keep_w(keep_w), .done_sa2(done_sa2), .active_sa2(active_sa2), .busy(busy),
        .a11(a11), .a12(a12), .a13(a13), .a14(a14), .a21(a21), .a22(a22), .a23(a23), .a24(a24),
        .a31(a31), .a32(a32), .a33(a33), .a34(a34), .a41(a41), .a42(a42), .a43(a43), .a44(a44),
        .b11(b11), .b12(b12), .b13(b13), .b21(b21), .b22(b22), .b23(b23),
        .b31(b31), .b32(b32), .b33(b33)
    );

    always #5 clk = ~clk;

    assign dut_a[0] = a11;  assign dut_a[1] = a12;  assign dut_a[2] = a13;  assign dut_a[3] = a14;
    assign dut_a[4] = a21;  assign dut_a[5] = a22;  assign dut_a[6] = a23;  assign dut_a[7] = a24;
    assign dut_a[8] = a31;  assign dut_a[9] = a32;  assign dut_a[10] = a33; assign dut_a[11] = a34;
    assign dut_a[12] = a41; assign dut_a[13] = a42; assign dut_a[14] = a43; assign dut_a[15] = a44;
    assign dut_b[0] = b11;  assign dut_b[1] = b12;  assign dut_b[2] = b13;
    assign dut_b[3] = b21;  assign dut_b[4] = b22;  assign dut_b[5] = b23;
    assign dut_b[6] = b31;  assign dut_b[7] = b32;  assign dut_b[8] = b33;

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) m_a[i] = '0;
        for (int i = 0; i < 9; i++) m_b[i] = '0;
        m_need_w = 1'b1;
        m_taken  = 0;
        m_phase  = 0;
    endfunction

    function automatic void modelEdge(input logic v, input logic [7:0] d, input logic dn, input logic kp);
        int total;
        int first_a;
        total   = m_need_w ? 25 : 16;
        first_a = m_need_w ? 9 : 0;
        case (m_phase)
            0: begin
                if (v) begin
                    if (m_taken < first_a) m_b[m_taken] = d;
                    else                   m_a[m_taken - first_a] = d;
                    m_taken++;
                    if (m_taken == total) m_phase = 1;
                end
            end
            1: m_phase = 2;
            default: begin
                if (dn) begin
                    m_need_w = !kp;
                    m_taken  = 0;
                    m_phase  = 0;
                end
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag);
        int bad;
        checks++;
        if ({in_ready, active_sa2, busy} !== {m_phase == 0, m_phase == 1, m_phase != 0}) begin
            errors++;
            $display("[TB] FAIL %s ctrl ready/active/busy got %b%b%b expected %b%b%b", tag,
                     in_ready, active_sa2, busy, m_phase == 0, m_phase == 1, m_phase != 0);
        end
        checks++;
        bad = -1;
        for (int i = 0; i < 16; i++) if (dut_a[i] !== m_a[i] && bad < 0) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s a[%0d] got 0x%h expected 0x%h", tag, bad, dut_a[bad], m_a[bad]);
        end
        checks++;
        bad = -1;
        for (int i = 0; i < 9; i++) if (dut_b[i] !== m_b[i] && bad < 0) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s b[%0d] got 0x%h expected 0x%h", tag, bad, dut_b[bad], m_b[bad]);
        end
    endtask

    task automatic expectEq(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic dn,
                                 input logic kp, input string tag);
        in_valid = v;
        in_data  = d;
        done_sa2 = dn;
        keep_w   = kp;
        @(posedge clk);
        modelEdge(v, d, dn, kp);
        cyc++;
        #1;
        if (active_sa2 === 1'b1) begin
            fire_count++;
            if (fire_cycle == 0) fire_cycle = cyc + 1;
        end
        checkOutput(tag);
    endtask

    task automatic resetDut();
        rst = 1'b0;
        modelReset();
        #1 checkOutput("reset");
        @(posedge clk);
        #1 checkOutput("reset_hold");
        rst = 1'b1;
        cyc = 0;
        fire_cycle = 0;
        fire_count = 0;
    endtask

    task automatic loadFrame(input bit toggle, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (toggle) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "load_gap");
            applyStimulus(1'b1, 8'(base + i), 1'b0, 1'b0, "load");
        end
    endtask

    typedef struct {
        bit toggle;
        int base;
        int exp_fire;
        int exp_b11;
        int exp_b33;
        int exp_a11;
        int exp_a44;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{toggle: 1'b0, base: 1,   exp_fire: 26, exp_b11: 1,   exp_b33: 9,   exp_a11: 10,  exp_a44: 25};
        vecs[1] = '{toggle: 1'b1, base: 1,   exp_fire: 51, exp_b11: 1,   exp_b33: 9,   exp_a11: 10,  exp_a44: 25};
        vecs[2] = '{toggle: 1'b0, base: 200, exp_fire: 26, exp_b11: 200, exp_b33: 208, exp_a11: 209, exp_a44: 224};

        #2;
        for (int v = 0; v < 3; v++) begin
            resetDut();
            loadFrame(vecs[v].toggle, vecs[v].base, 25);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "to_wait");
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "wait");
            expectEq("fire_cycle", fire_cycle, vecs[v].exp_fire);
            expectEq("fire_count", fire_count, 1);
            expectEq("b11", int'(b11), vecs[v].exp_b11);
            expectEq("b33", int'(b33), vecs[v].exp_b33);
            expectEq("a11", int'(a11), vecs[v].exp_a11);
            expectEq("a44", int'(a44), vecs[v].exp_a44);
            expectEq("busy_wait", int'(busy), 1);
        end

        // Fresh frame of 1..25, then hammer in_valid with 0xFF while waiting.
        resetDut();
        loadFrame(1'b0, 1, 25);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "to_wait");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, "wait_ff");
            expectEq("wait_ready", int'(in_ready), 0);
        end
        expectEq("wait_a44_kept", int'(a44), 25);

        // Reuse the kernel: only 16 tile bytes follow the done edge.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "done_keep");
        cyc = 0;
        fire_cycle = 0;
        fire_count = 0;
        loadFrame(1'b0, 100, 16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "keep_wait");
        expectEq("keep_fire_cycle", fire_cycle, 17);
        expectEq("keep_fire_count", fire_count, 1);
        expectEq("keep_b11", int'(b11), 1);
        expectEq("keep_b33", int'(b33), 9);
        expectEq("keep_a11", int'(a11), 100);
        expectEq("keep_a44", int'(a44), 115);

        // A done pulse during the tile load must be ignored.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "done_reload");
        fire_count = 0;
        loadFrame(1'b0, 30, 9);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 8'(40 + i), (i == 6), 1'b0, "load_a_done");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "stray_wait");
        expectEq("stray_fire_count", fire_count, 1);
        expectEq("stray_a44", int'(a44), 55);

        // Abort a frame after 12 transfers, then load a clean one.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "done_abort");
        loadFrame(1'b0, 70, 12);
        resetDut();
        expectEq("abort_b11", int'(b11), 0);
        expectEq("abort_a11", int'(a11), 0);
        expectEq("abort_ready", int'(in_ready), 1);
        loadFrame(1'b0, 60, 25);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "abort_wait");
        expectEq("abort_fire_cycle", fire_cycle, 26);
        expectEq("abort_b11_new", int'(b11), 60);

        // Randomized traffic with occasional done pulses and mid-frame resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetDut();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
